// File: rtl/deca_vip_rdm_pkg.sv
// Shared types, default widths and address helpers for the VIP memory stream reader.
package deca_vip_rdm_pkg;

  localparam int RDM_ADDR_W    = 15;
  localparam int RDM_DATA_W    = 32;
  localparam int RDM_MEM_WORDS = 17500;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rdm_state_e;

  // Next word address; the memory is not a power of two deep, so wrap explicitly.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned words);
    return (addr + 1 >= words) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/deca_vip_rdm_fifo.sv
// Show-ahead FIFO holding returned read words (with sop/eop tags) ahead of the stream port.
module deca_vip_rdm_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/deca_vip_mem_stream_reader.sv
// Avalon-MM read master that streams a programmed run of memory words out as an
// Avalon-ST packet, using read credits so in-flight data always fits the FIFO.
module deca_vip_mem_stream_reader
  import deca_vip_rdm_pkg::*;
#(
  parameter int ADDR_W       = RDM_ADDR_W,
  parameter int DATA_W       = RDM_DATA_W,
  parameter int MEM_WORDS    = RDM_MEM_WORDS,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int ENT_W = DATA_W + 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rdm_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [15:0]             remaining_q, remaining_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             rx_idx_q, rx_idx_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [7:0]              inflight_cnt;
  logic                    issue, credit_ok, push, pop;
  logic [ENT_W-1:0]        push_ent, head_ent;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    head_sop, head_eop;

  // Words are tagged on arrival by their position in the run, so the stream side needs no counter.
  assign push     = pipe_q[READ_LATENCY-1];
  assign push_ent = {(rx_idx_q == 16'd0), (rx_idx_q == len_q - 16'd1), m_readdata};
  assign head_sop = head_ent[ENT_W-1];
  assign head_eop = head_ent[ENT_W-2];
  assign pop      = st_valid && st_ready;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + 8'(pipe_q[i]);
    end
  end

  // Pops are not credited back early; issuing stays safe without a combinational path from st_ready.
  assign credit_ok = !fifo_full &&
                     ((32'(fifo_count) + 32'(inflight_cnt)) < 32'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    rx_idx_d    = rx_idx_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    pipe_d      = pipe_q << 1;
    if (push) begin
      rx_idx_d = rx_idx_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != 16'd0) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            len_d       = word_count;
            rx_idx_d    = 16'd0;
            state_d     = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue       = 1'b1;
          addr_d      = ADDR_W'(wrap_inc(32'(addr_q), 32'(MEM_WORDS)));
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_eop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    pipe_d[0] = issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      rx_idx_q    <= '0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      rx_idx_q    <= rx_idx_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
    end
  end

  deca_vip_rdm_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(push_ent),
    .rdata(head_ent),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_clken      = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign st_valid     = !fifo_empty;
  assign st_data      = head_ent[DATA_W-1:0];
  assign st_sop       = st_valid && head_sop;
  assign st_eop       = st_valid && head_eop;

endmodule
